aes_block_dma_master: RTL and testbench
=======================================

// Module: aes_block_dma_master
// PURPOSE
//  Avalon-MM master (initiator) that drives the 32-bit on-chip memory slave: it fetches
//  128-bit AES blocks from a source buffer, emits each on a valid/ready stream to the
//  AES core, accepts the processed 128-bit block back, and writes it to a destination
//  buffer. Sits between the memory interconnect and the AES encrypt/decrypt datapath;
//  started by the Nios II via start/src/dst/count.
// PARAMETERS
//  ADDR_W   16  byte-address width of avm_address (64 KiB window, 16384 words)
//  CNT_W    12  width of num_blocks (max 4095 blocks per run)
// PORTS
//  clk               in   1        system clock
//  reset_n           in   1        asynchronous active-low reset
//  start             in   1        1-cycle request to begin a run; ignored while busy
//  src_addr          in   ADDR_W   source byte address; bits [3:0] forced to 0
//  dst_addr          in   ADDR_W   destination byte address; bits [3:0] forced to 0
//  num_blocks        in   CNT_W    number of 16-byte blocks to process
//  busy              out  1        high from accepted start until done
//  done              out  1        1-cycle pulse when the run completes
//  avm_address       out  ADDR_W   byte address, always word-aligned
//  avm_read          out  1        read request
//  avm_write         out  1        write request
//  avm_byteenable    out  4        always 4'hF when read/write asserted, else 0
//  avm_writedata     out  32       write data
//  avm_readdata      in   32       read data
//  avm_readdatavalid in   1        read data qualifier
//  avm_waitrequest   in   1        slave stall; holds the current request
//  blk_out_data      out  128      fetched block; word at lowest address in [31:0]
//  blk_out_valid     out  1        blk_out_data valid
//  blk_out_ready     in   1        AES core accepts block
//  blk_in_data       in   128      processed block; [31:0] written to lowest address
//  blk_in_valid      in   1        processed block valid
//  blk_in_ready      out  1        this block accepts processed block
// BEHAVIOUR
//  Reset (async, any state): FSM->IDLE; all outputs 0; counters/addr regs 0.
//  FSM: IDLE -start-> (num_blocks==0 ? FIN : RD_REQ)
//       RD_REQ: avm_read=1, addr=src_ptr+4*w; stay while waitrequest; on accept -> RD_WAIT
//       RD_WAIT: on readdatavalid capture word w into blk[32w+:32];
//                w<3 -> w++, RD_REQ; w==3 -> OUT
//       OUT: blk_out_valid=1; on blk_out_ready -> IN
//       IN: blk_in_ready=1; on blk_in_valid latch blk_in_data, w=0 -> WR
//       WR: avm_write=1, addr=dst_ptr+4*w, writedata=res[32w+:32]; hold while waitrequest;
//           on accept w<3 -> w++; w==3 -> NEXT
//       NEXT: src_ptr+=16, dst_ptr+=16, blocks_left--; left==0 -> FIN else RD_REQ
//       FIN: done=1 for exactly one cycle, busy drops same cycle -> IDLE
//  - One outstanding read max; avm_read/avm_write never both high; address, data,
//    byteenable stable while waitrequest high.
//  - readdatavalid outside RD_WAIT is ignored.
//  - start, src_addr, dst_addr, num_blocks sampled only in IDLE on start=1.
//  - Address arithmetic modulo 2^ADDR_W (wraps 0xFFF0 -> 0x0000, no error).
//  - Zero-wait bus, readdatavalid 1 cycle after accept: 8 cycles per 4-word read,
//    4 cycles write, +1 NEXT; OUT/IN each >=1 cycle.
//  - busy rises the cycle after accepted start; done and busy never high together
//    except done's single FIN cycle (busy=0 in FIN).
//  - Overlapping src/dst legal: each block fully read before written.
// TESTING
//  1 start src=0x0000 dst=0x0100 n=1, zero wait, loopback core -> 4 reads 0x0..0xC,
//    4 writes 0x100..0x10C, memory copy exact, one done pulse
//  2 n=0 -> no avm_read/avm_write, done pulse 1 cycle after start, busy stays 0
//  3 random waitrequest (50%) n=3 -> address/data held while stalled, 12 reads/12 writes
//  4 src=0xFFF0 n=2 -> second block reads 0x0000..0x000C (wrap)
//  5 blk_out_ready/blk_in_valid delayed 10 cycles; start pulsed mid-run -> ignored
//  6 reset_n low in RD_WAIT and in WR -> all outputs 0 immediately; new run works

Source files
------------

// File: rtl/aes_block_dma_master.sv
// Avalon-MM master that streams 128-bit blocks from a source buffer through the AES
// core and back to a destination buffer, one 32-bit word per bus transfer.
module aes_block_dma_master #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [CNT_W-1:0]  num_blocks,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest,
  output logic [127:0]      blk_out_data,
  output logic              blk_out_valid,
  input  logic              blk_out_ready,
  input  logic [127:0]      blk_in_data,
  input  logic              blk_in_valid,
  output logic              blk_in_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_OUT, S_IN, S_WR, S_NEXT, S_FIN
  } state_t;

  localparam logic [ADDR_W-1:0] BLK_BYTES = ADDR_W'(16);

  state_t            r_state;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [CNT_W-1:0]  r_left;
  logic [1:0]        r_w;
  logic [127:0]      r_blk;
  logic [127:0]      r_res;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rd;
  logic              r_wr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic              r_ovld;
  logic              r_irdy;

  logic [ADDR_W-1:0] w_src_aligned;
  logic [ADDR_W-1:0] w_dst_aligned;
  logic [1:0]        w_w_inc;

  assign w_src_aligned = {src_addr[ADDR_W-1:4], 4'h0};
  assign w_dst_aligned = {dst_addr[ADDR_W-1:4], 4'h0};
  assign w_w_inc       = r_w + 2'd1;

  // Word address inside a 16-byte block; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [1:0] w);
    return base + ADDR_W'({w, 2'b00});
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_left  <= '0;
      r_w     <= '0;
      r_blk   <= '0;
      r_res   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_addr  <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_be    <= 4'h0;
      r_wdata <= '0;
      r_ovld  <= 1'b0;
      r_irdy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_src  <= w_src_aligned;
            r_dst  <= w_dst_aligned;
            r_left <= num_blocks;
            r_w    <= 2'd0;
            if (num_blocks == '0) begin
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_busy  <= 1'b1;
              r_rd    <= 1'b1;
              r_be    <= 4'hF;
              r_addr  <= w_src_aligned;
              r_state <= S_RD_REQ;
            end
          end
        end
        S_RD_REQ: begin
          if (!avm_waitrequest) begin
            r_rd    <= 1'b0;
            r_be    <= 4'h0;
            r_state <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (avm_readdatavalid) begin
            r_blk[{r_w, 5'b0} +: 32] <= avm_readdata;
            if (r_w == 2'd3) begin
              r_ovld  <= 1'b1;
              r_state <= S_OUT;
            end else begin
              r_w     <= w_w_inc;
              r_rd    <= 1'b1;
              r_be    <= 4'hF;
              r_addr  <= word_addr(r_src, w_w_inc);
              r_state <= S_RD_REQ;
            end
          end
        end
        S_OUT: begin
          if (blk_out_ready) begin
            r_ovld  <= 1'b0;
            r_irdy  <= 1'b1;
            r_state <= S_IN;
          end
        end
        S_IN: begin
          if (blk_in_valid) begin
            r_irdy  <= 1'b0;
            r_res   <= blk_in_data;
            r_w     <= 2'd0;
            r_wr    <= 1'b1;
            r_be    <= 4'hF;
            r_addr  <= r_dst;
            r_wdata <= blk_in_data[31:0];
            r_state <= S_WR;
          end
        end
        S_WR: begin
          if (!avm_waitrequest) begin
            if (r_w == 2'd3) begin
              r_wr    <= 1'b0;
              r_be    <= 4'h0;
              r_state <= S_NEXT;
            end else begin
              r_w     <= w_w_inc;
              r_addr  <= word_addr(r_dst, w_w_inc);
              r_wdata <= r_res[{w_w_inc, 5'b0} +: 32];
            end
          end
        end
        S_NEXT: begin
          // Pointers advance even on the last block so a later run starts clean.
          r_src  <= r_src + BLK_BYTES;
          r_dst  <= r_dst + BLK_BYTES;
          r_left <= r_left - CNT_W'(1);
          r_w    <= 2'd0;
          if (r_left == CNT_W'(1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_rd    <= 1'b1;
            r_be    <= 4'hF;
            r_addr  <= r_src + BLK_BYTES;
            r_state <= S_RD_REQ;
          end
        end
        S_FIN: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign avm_address    = r_addr;
  assign avm_read       = r_rd;
  assign avm_write      = r_wr;
  assign avm_byteenable = r_be;
  assign avm_writedata  = r_wdata;
  assign blk_out_data   = r_blk;
  assign blk_out_valid  = r_ovld;
  assign blk_in_ready   = r_irdy;

endmodule

// File: tb/tb_aes_block_dma_master.sv
// Scoreboard bench: memory slave + AES-core stand-in, expected traffic from a block-level model.
module tb_aes_block_dma_master;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         start = 1'b0;
  logic [15:0]  src_addr = '0;
  logic [15:0]  dst_addr = '0;
  logic [11:0]  num_blocks = '0;
  logic         busy, done;
  logic [15:0]  avm_address;
  logic         avm_read, avm_write;
  logic [3:0]   avm_byteenable;
  logic [31:0]  avm_writedata;
  logic [31:0]  avm_readdata = '0;
  logic         avm_readdatavalid = 1'b0;
  logic         avm_waitrequest = 1'b0;
  logic [127:0] blk_out_data;
  logic         blk_out_valid;
  logic         blk_out_ready = 1'b0;
  logic [127:0] blk_in_data = '0;
  logic         blk_in_valid = 1'b0;
  logic         blk_in_ready;

  aes_block_dma_master #(.ADDR_W(16), .CNT_W(12)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .num_blocks(num_blocks),
    .busy(busy), .done(done),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .avm_waitrequest(avm_waitrequest),
    .blk_out_data(blk_out_data), .blk_out_valid(blk_out_valid), .blk_out_ready(blk_out_ready),
    .blk_in_data(blk_in_data), .blk_in_valid(blk_in_valid), .blk_in_ready(blk_in_ready)
  );

  always #5 clk = ~clk;

  logic [31:0]  mem  [16384];
  logic [31:0]  rmem [16384];
  logic [15:0]  q_rd  [$];
  logic [127:0] q_blk [$];
  logic [47:0]  q_wr  [$];

  int n_chk = 0, n_pass = 0;
  int ws_pct = 0, dly = 0;
  bit spur_en = 1'b0;
  logic [127:0] key = '0;
  int done_cnt = 0, busy_cyc = 0, overlap_err = 0, n_rd = 0, n_wr = 0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h required %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic check_reset(input string nm);
    check(nm, 256'({busy, done, avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
                    blk_out_data, blk_out_valid, blk_in_ready}), 256'(0));
  endtask

  // Reference: each block is four consecutive words read, transformed by XOR key, written back.
  task automatic model_run(input logic [15:0] s, input logic [15:0] d, input int n);
    logic [15:0] sb, db, a;
    logic [127:0] blk, res;
    sb = {s[15:4], 4'h0};
    db = {d[15:4], 4'h0};
    for (int b = 0; b < n; b++) begin
      for (int w = 0; w < 4; w++) begin
        a = sb + 16'(16 * b + 4 * w);
        q_rd.push_back(a);
        blk[32*w +: 32] = rmem[a[15:2]];
      end
      q_blk.push_back(blk);
      res = blk ^ key;
      for (int w = 0; w < 4; w++) begin
        a = db + 16'(16 * b + 4 * w);
        q_wr.push_back({a, res[32*w +: 32]});
        rmem[a[15:2]] = res[32*w +: 32];
      end
    end
  endtask

  // Slave, core stand-in and monitor all act on the falling edge for the next rising edge.
  bit           pending = 1'b0;
  logic [15:0]  paddr = '0;
  bit           prev_stall = 1'b0;
  logic [53:0]  prev_req = '0;
  int           cstate = 0, cnt = 0;
  logic [127:0] cap = '0;
  logic [47:0]  wexp;

  always @(negedge clk) begin
    if (!reset_n) begin
      pending = 1'b0; prev_stall = 1'b0; cstate = 0; cnt = 0;
      avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
      blk_out_ready = 1'b0; blk_in_valid = 1'b0;
    end else begin
      if (pending) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = mem[paddr[15:2]];
        pending = 1'b0;
      end else begin
        avm_readdatavalid = spur_en && ($urandom_range(7) == 0);
        avm_readdata = $urandom;
      end
      if (prev_stall)
        check("stall_hold", 256'({avm_read, avm_write, avm_address, avm_byteenable,
                                  avm_write ? avm_writedata : 32'h0}), 256'(prev_req));
      prev_stall = 1'b0;
      avm_waitrequest = 1'b0;
      if (avm_read || avm_write) begin
        avm_waitrequest = ($urandom_range(99) < ws_pct);
        if (avm_waitrequest) begin
          prev_stall = 1'b1;
          prev_req = {avm_read, avm_write, avm_address, avm_byteenable,
                      avm_write ? avm_writedata : 32'h0};
        end else begin
          check("rd_wr_exclusive", 256'(avm_read & avm_write), 256'(0));
          check("byteenable", 256'(avm_byteenable), 256'(4'hF));
          if (avm_read) begin
            n_rd++;
            if (q_rd.size() == 0) begin
              n_chk++; $display("FAIL rd_extra: got read at %h required none", avm_address);
            end else check("rd_addr", 256'(avm_address), 256'(q_rd.pop_front()));
            pending = 1'b1;
            paddr = avm_address;
          end else begin
            n_wr++;
            if (q_wr.size() == 0) begin
              n_chk++; $display("FAIL wr_extra: got write at %h required none", avm_address);
            end else begin
              wexp = q_wr.pop_front();
              check("wr_addr", 256'(avm_address), 256'(wexp[47:32]));
              check("wr_data", 256'(avm_writedata), 256'(wexp[31:0]));
            end
            mem[avm_address[15:2]] = avm_writedata;
          end
        end
      end
      case (cstate)
        0: begin
          blk_in_valid = 1'b0;
          blk_in_data = {$urandom, $urandom, $urandom, $urandom};
          if (blk_out_valid) begin
            if (cnt >= dly) begin
              blk_out_ready = 1'b1;
              if (q_blk.size() == 0) begin
                n_chk++; $display("FAIL blk_extra: got block %h required none", blk_out_data);
              end else check("blk_out", 256'(blk_out_data), 256'(q_blk.pop_front()));
              cap = blk_out_data;
              cstate = 1; cnt = 0;
            end else cnt++;
          end else cnt = 0;
        end
        1: begin
          blk_out_ready = 1'b0;
          if (cnt >= dly) begin
            blk_in_valid = 1'b1;
            blk_in_data = cap ^ key;
            if (blk_in_ready) cstate = 2;
          end else cnt++;
        end
        default: begin
          blk_in_valid = 1'b0;
          blk_in_data = {$urandom, $urandom, $urandom, $urandom};
          cstate = 0; cnt = 0;
        end
      endcase
      if (done) begin
        done_cnt++;
        if (busy) overlap_err++;
      end
      if (busy) busy_cyc++;
    end
  end

  task automatic start_pulse(input logic [15:0] s, input logic [15:0] d, input logic [11:0] n);
    @(negedge clk); #1;
    start = 1'b1; src_addr = s; dst_addr = d; num_blocks = n;
    @(negedge clk); #1;
    start = 1'b0; src_addr = $urandom; dst_addr = $urandom; num_blocks = 12'($urandom);
  endtask

  task automatic run(input logic [15:0] s, input logic [15:0] d, input int n, input int wsp,
                     input int dl, input bit mid, input bit spur, input bit cyc);
    int d0, b0, r0, w0;
    ws_pct = wsp; dly = dl; spur_en = spur;
    model_run(s, d, n);
    d0 = done_cnt; b0 = busy_cyc; r0 = n_rd; w0 = n_wr;
    start_pulse(s, d, 12'(n));
    check("busy_after_start", 256'(busy), 256'(n != 0));
    check("done_after_start", 256'(done), 256'(n == 0));
    for (int i = 0; i < 20000; i++) begin
      if (done_cnt != d0) break;
      @(negedge clk); #1;
      if (mid) begin
        if (i == 30) begin
          start = 1'b1; src_addr = 16'h9990; dst_addr = 16'hA000; num_blocks = 12'd5;
        end else start = 1'b0;
      end
    end
    start = 1'b0;
    check("done_seen", 256'(done_cnt - d0), 256'(1));
    @(negedge clk); #1;
    check("done_one_cycle", 256'(done), 256'(0));
    check("busy_idle", 256'(busy), 256'(0));
    check("read_count", 256'(n_rd - r0), 256'(4 * n));
    check("write_count", 256'(n_wr - w0), 256'(4 * n));
    check("blk_queue_empty", 256'(q_blk.size()), 256'(0));
    if (cyc) check("busy_cycles", 256'(busy_cyc - b0), 256'(15 * n));
  endtask

  task automatic reset_mid(input bit in_wr);
    int r0;
    ws_pct = 0; dly = 0; spur_en = 1'b0;
    model_run(16'h6000, 16'h6100, 2);
    r0 = n_rd;
    start_pulse(16'h6000, 16'h6100, 12'd2);
    for (int i = 0; i < 2000; i++) begin
      if (!in_wr && n_rd >= r0 + 2) break;
      if (in_wr && avm_write) break;
      @(negedge clk); #1;
    end
    if (!in_wr) begin
      @(posedge clk); #2;
    end
    reset_n = 1'b0;
    #1;
    check_reset(in_wr ? "reset_in_wr" : "reset_in_rd_wait");
    repeat (2) @(negedge clk);
    #1;
    q_rd.delete(); q_blk.delete(); q_wr.delete();
    for (int i = 0; i < 16384; i++) rmem[i] = mem[i];
    reset_n = 1'b1;
  endtask

  initial begin
    int mism;
    for (int i = 0; i < 16384; i++) begin
      mem[i] = $urandom;
      rmem[i] = mem[i];
    end
    #2 reset_n = 1'b0;
    #1 check_reset("reset_init");
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;

    key = '0;
    run(16'h0000, 16'h0100, 1, 0, 0, 1'b0, 1'b0, 1'b1);
    run(16'h1230, 16'h1230, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    key = {$urandom, $urandom, $urandom, $urandom};
    run(16'h0200, 16'h0A07, 3, 50, 0, 1'b0, 1'b1, 1'b0);
    run(16'hFFF0, 16'h2000, 2, 0, 0, 1'b0, 1'b0, 1'b1);
    run(16'h3000, 16'h3100, 2, 0, 10, 1'b1, 1'b0, 1'b0);
    reset_mid(1'b0);
    reset_mid(1'b1);
    run(16'h4003, 16'h400F, 2, 0, 0, 1'b0, 1'b0, 1'b1);
    run(16'h5000, 16'h5010, 3, 20, 1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      run(16'($urandom), 16'($urandom), int'($urandom_range(4, 1)), int'($urandom_range(60)),
          int'($urandom_range(3)), 1'b0, 1'b1, 1'b0);
    end

    check("be_when_idle", 256'(avm_byteenable), 256'(0));
    check("done_busy_overlap", 256'(overlap_err), 256'(0));
    mism = 0;
    for (int i = 0; i < 16384; i++) if (mem[i] !== rmem[i]) mism++;
    check("memory_image", 256'(mism), 256'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
